// File: rtl/pool_pkg.sv
// Shared constants, sizing helpers and FSM encoding for the 2x2 max-pool stream.
package pool_pkg;

  localparam int DATA_W = 8;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Pooled dimension for a 2x2 / stride-2 window: floor(n/2).
  function automatic int pool_dim(input int n);
    return n / 2;
  endfunction

  // Counter/address width that never collapses to zero bits.
  function automatic int bits_for(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Unsigned 8-bit maximum.
  function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/pool_line_buffer.sv
// One-row buffer of horizontal pair maxima. Simple dual-port RAM with a
// registered read whose output only changes when rd_en is asserted, so a
// fetched value survives any number of idle input cycles.
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int DEPTH = 14,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_q
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Write port: store the even-row pair maximum.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: output register loads only on rd_en and holds otherwise.
  always_ff @(posedge clk) begin
    if (rd_en) rd_q <= mem[rd_addr];
  end

endmodule

// File: rtl/maxpool2d_stream.sv
// 2x2 stride-2 max pooling over a raster, channel-major 8-bit stream.
// Even rows leave pair maxima in the line buffer; odd rows combine them with
// their own pair to produce one pooled byte plus its linear write address.
module maxpool2d_stream
  import pool_pkg::*;
#(
  parameter  int IN_W     = 28,
  parameter  int IN_H     = 28,
  parameter  int CHANNELS = 32,
  localparam int OUT_W    = pool_dim(IN_W),
  localparam int OUT_H    = pool_dim(IN_H),
  localparam int ADDR_W   = bits_for(CHANNELS * OUT_H * OUT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = bits_for(IN_W);
  localparam int ROW_W = bits_for(IN_H);
  localparam int CH_W  = bits_for(CHANNELS);
  localparam int LB_AW = bits_for(OUT_W);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam bit ODD_W = (IN_W % 2) != 0;

  state_t            state_reg, state_next;
  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [CH_W-1:0]   ch_reg;
  logic [DATA_W-1:0] hold_reg;
  logic [ADDR_W-1:0] pix_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_valid_reg;
  logic [ADDR_W-1:0] out_addr_reg;
  logic              done_reg;

  logic              beat, col_last, row_last, ch_last, frame_last;
  logic              lb_wr_en, lb_rd_en, out_fire;
  logic [LB_AW-1:0]  lb_addr;
  logic [DATA_W-1:0] lb_q;

  assign beat       = in_valid && (state_reg == RUN);
  assign col_last   = (col_reg == COL_LAST);
  assign row_last   = (row_reg == ROW_LAST);
  assign ch_last    = (ch_reg == CH_LAST);
  assign frame_last = col_last && row_last && ch_last;

  // A trailing unpaired column (odd width) never touches the line buffer;
  // odd rows are always inside the pooled height, so no row guard is needed.
  assign lb_addr  = LB_AW'(col_reg >> 1);
  assign lb_wr_en = beat && !row_reg[0] && col_reg[0];
  assign lb_rd_en = beat && row_reg[0] && !col_reg[0] && !(ODD_W && col_last);
  assign out_fire = beat && row_reg[0] && col_reg[0];

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM next state: arm on start, finish on the frame's last beat.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (beat && frame_last) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Raster position counters: col -> row -> ch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
      ch_reg  <= '0;
    end else if (state_reg == IDLE && start) begin
      col_reg <= '0;
      row_reg <= '0;
      ch_reg  <= '0;
    end else if (beat) begin
      if (col_last) begin
        col_reg <= '0;
        if (row_last) begin
          row_reg <= '0;
          ch_reg  <= ch_last ? '0 : ch_reg + 1'b1;
        end else begin
          row_reg <= row_reg + 1'b1;
        end
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // Left element of each horizontal pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      hold_reg <= '0;
    else if (beat && !col_reg[0]) hold_reg <= in_data;
  end

  // Output stage; windows complete in ascending address order, so a running
  // count equals ch*OUT_H*OUT_W + prow*OUT_W + pcol.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_addr_reg  <= '0;
      pix_reg       <= '0;
    end else begin
      out_valid_reg <= out_fire;
      if (state_reg == IDLE && start) begin
        pix_reg <= '0;
      end else if (out_fire) begin
        out_data_reg <= max2(max2(lb_q, hold_reg), in_data);
        out_addr_reg <= pix_reg;
        pix_reg      <= pix_reg + 1'b1;
      end
    end
  end

  // done follows the FIN cycle, landing one cycle after the last output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_reg <= 1'b0;
    else     done_reg <= (state_reg == FIN);
  end

  pool_line_buffer #(
    .DEPTH (OUT_W),
    .AW    (LB_AW)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_addr),
    .wr_data (max2(hold_reg, in_data)),
    .rd_en   (lb_rd_en),
    .rd_addr (lb_addr),
    .rd_q    (lb_q)
  );

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_addr  = out_addr_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;

endmodule
